drops_button_conditioner: RTL and testbench

Input-side front end for the drops game: takes the raw, asynchronous up/down push-button levels from the dedicated inputs (`ui_in[0]` = up, `ui_in[1]` = down) and turns them into clean single-cycle move pulses for the game core. It synchronises, debounces and edge-detects each button, and generates auto-repeat pulses while a button is held. It sits between the top-level pin mapping and the player-position logic. It owns the interface from the game's button inputs back to the pins.

---
 rtl/drops_button_conditioner.sv | 166 ++++++++++++++++
 tb/tb_drops_button_conditioner.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drops_button_conditioner.sv
// rtl/drops_button_conditioner.sv - synchronise, debounce, edge-detect and auto-repeat the drops up/down buttons
//
// Ports:
//   clk                   system clock
//   rst_n                 asynchronous active-low reset
//   ena                   design enable; low forces both repeat FSMs idle and suppresses pulses
//   btn_up, btn_down      raw asynchronous button levels, active high
//   up_pulse, down_pulse  one-cycle move strobes (press pulse plus auto-repeat)
//   up_held, down_held    debounced button levels, not gated by ena
//
// Channel 0 is up, channel 1 is down. Both channels are identical.

module drops_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 250000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic btn_up,
  input  logic btn_down,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_held,
  output logic down_held
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW_D = $clog2(REPEAT_DELAY + 1);
  localparam int TW_R = $clog2(REPEAT_RATE + 1);
  localparam int TW   = (TW_D > TW_R) ? TW_D : TW_R;

  // Terminal counts are one below the parameter: the counter value seen
  // before an edge is the number of edges already elapsed.
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [1:0] btn_raw;
  logic [1:0] held_next;
  logic [1:0] held_cur;
  logic [1:0] pulse_cur;
  logic       both_held;

  assign btn_raw = {btn_down, btn_up};

  // Conflict is judged on the next debounced levels so that a channel whose
  // level rises while the other is already held never emits its press pulse.
  assign both_held = held_next[0] & held_next[1];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          held_q;
    logic          held_d;
    state_e        state_q;
    state_e        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [TW-1:0] timer_inc;
    logic          pulse_q;
    logic          pulse_d;
    logic          rise;

    assign held_next[g] = held_d;
    assign held_cur[g]  = held_q;
    assign pulse_cur[g] = pulse_q;
    assign rise         = held_d & ~held_q;
    assign timer_inc    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        db_cnt_q <= '0;
        held_q   <= 1'b0;
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        pulse_q  <= 1'b0;
      end else begin
        sync1_q  <= btn_raw[g];
        sync2_q  <= sync1_q;
        db_cnt_q <= db_cnt_d;
        held_q   <= held_d;
        state_q  <= state_d;
        timer_q  <= timer_d;
        pulse_q  <= pulse_d;
      end
    end

    // Debounce: count consecutive samples that disagree with the held level;
    // the counter clears on the flip, so it never exceeds DEBOUNCE_CYCLES.
    always_comb begin
      db_cnt_d = '0;
      held_d   = held_q;
      if (sync2_q != held_q) begin
        if (db_cnt_q == DB_LAST) begin
          held_d = sync2_q;
        end else begin
          db_cnt_d = db_cnt_q + DW'(1);
        end
      end
    end

    // Repeat FSM. The pulse is registered alongside held_q so the press
    // pulse lands in the same cycle the debounced level first reads high.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pulse_d = 1'b0;
      if (!ena || !held_d || both_held) begin
        state_d = ST_IDLE;
        timer_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              pulse_d = 1'b1;
              timer_d = '0;
              if (REPEAT_DELAY != 0) begin
                state_d = ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            if (timer_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              timer_d = '0;
              state_d = ST_REPEAT;
            end else begin
              timer_d = timer_inc;
            end
          end
          ST_REPEAT: begin
            if (timer_q == RATE_LAST) begin
              pulse_d = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_inc;
            end
          end
          default: begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        endcase
      end
    end
  end

  assign up_held    = held_cur[0];
  assign down_held  = held_cur[1];
  assign up_pulse   = pulse_cur[0];
  assign down_pulse = pulse_cur[1];

endmodule

// File: tb/tb_drops_button_conditioner.sv
// tb/tb_drops_button_conditioner.sv - self-checking bench for drops_button_conditioner

module tb_drops_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk;
  logic rst_n;
  logic ena;
  logic btn_up;
  logic btn_down;
  logic up_pulse, down_pulse, up_held, down_held;
  logic up_pulse0, down_pulse0, up_held0, down_held0;

  int n_checks;
  int n_fail;

  drops_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .up_held   (up_held),
    .down_held (down_held)
  );

  drops_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (0),
    .REPEAT_RATE    (RR)
  ) dut_norep (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .up_pulse  (up_pulse0),
    .down_pulse(down_pulse0),
    .up_held   (up_held0),
    .down_held (down_held0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the debounced level flips once the last D samples seen
  // through the two-stage synchroniser all disagree with it; pulses follow
  // from the age of the current valid press.
  bit   hist [2][D+2];
  bit   m_held [2];
  bit   run_act [2][2];
  int   run_age [2][2];
  bit   m_pulse [2][2];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < D + 2; i++) hist[c][i] = 1'b0;
      m_held[c] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        run_act[k][c] = 1'b0;
        run_age[k][c] = 0;
        m_pulse[k][c] = 1'b0;
      end
    end
  endfunction

  function automatic void model_step();
    bit raw [2];
    bit nh [2];
    bit all_diff;
    int rd;
    raw[0] = btn_up;
    raw[1] = btn_down;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < D + 1; i++) hist[c][i] = hist[c][i+1];
      hist[c][D+1] = raw[c];
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (hist[c][i] == m_held[c]) all_diff = 1'b0;
      nh[c] = all_diff ? ~m_held[c] : m_held[c];
    end
    for (int k = 0; k < 2; k++) begin
      rd = (k == 0) ? RD : 0;
      for (int c = 0; c < 2; c++) begin
        if (!ena || !nh[c] || nh[1-c]) begin
          run_act[k][c] = 1'b0;
          m_pulse[k][c] = 1'b0;
        end else if (!m_held[c]) begin
          run_act[k][c] = 1'b1;
          run_age[k][c] = 0;
          m_pulse[k][c] = 1'b1;
        end else if (run_act[k][c]) begin
          run_age[k][c] = run_age[k][c] + 1;
          m_pulse[k][c] = (rd != 0) && (run_age[k][c] >= rd) && ((run_age[k][c] - rd) % RR == 0);
        end else begin
          m_pulse[k][c] = 1'b0;
        end
      end
    end
    m_held[0] = nh[0];
    m_held[1] = nh[1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int cnt_up, cnt_dn, cnt_up0;

  task automatic check_model();
    check("model up_held", up_held, m_held[0]);
    check("model down_held", down_held, m_held[1]);
    check("model up_pulse", up_pulse, m_pulse[0][0]);
    check("model down_pulse", down_pulse, m_pulse[0][1]);
    check("model norep up_held", up_held0, m_held[0]);
    check("model norep down_held", down_held0, m_held[1]);
    check("model norep up_pulse", up_pulse0, m_pulse[1][0]);
    check("model norep down_pulse", down_pulse0, m_pulse[1][1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check_model();
    cnt_up  += int'(up_pulse);
    cnt_dn  += int'(down_pulse);
    cnt_up0 += int'(up_pulse0);
  endtask

  typedef struct {
    bit up;
    bit dn;
    bit en;
    int cycles;
    int exp_up;
    int exp_dn;
    bit exp_uh;
    bit exp_dh;
  } phase_t;

  function automatic phase_t mk(bit up, bit dn, bit en, int cycles, int eu, int ed, bit uh, bit dh);
    phase_t p;
    p.up = up; p.dn = dn; p.en = en; p.cycles = cycles;
    p.exp_up = eu; p.exp_dn = ed; p.exp_uh = uh; p.exp_dh = dh;
    return p;
  endfunction

  phase_t tbl [16];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cnt_up = 0; cnt_dn = 0; cnt_up0 = 0;

    tbl[0]  = mk(0, 0, 1, 10, 0,  0, 0, 0);  // idle
    tbl[1]  = mk(0, 1, 1,  3, 0,  0, 0, 0);  // 3-cycle glitch on down
    tbl[2]  = mk(0, 0, 1,  8, 0,  0, 0, 0);
    tbl[3]  = mk(0, 1, 1,  8, 0,  1, 0, 1);  // real down press
    tbl[4]  = mk(0, 0, 1,  8, 0,  0, 0, 0);  // release before first repeat
    tbl[5]  = mk(1, 0, 1, 44, 11, 0, 1, 0);  // press + repeats t0+10..t0+37
    tbl[6]  = mk(0, 0, 1,  8, 2,  0, 0, 0);  // repeats t0+40, t0+43 before held falls
    tbl[7]  = mk(1, 0, 1,  8, 1,  0, 1, 0);  // up press
    tbl[8]  = mk(1, 1, 1, 10, 0,  0, 1, 1);  // down while up held: silence
    tbl[9]  = mk(1, 0, 1, 10, 0,  0, 1, 0);  // release down: still silent
    tbl[10] = mk(0, 0, 1,  8, 0,  0, 0, 0);
    tbl[11] = mk(0, 1, 1,  8, 0,  1, 0, 1);  // re-press down
    tbl[12] = mk(0, 0, 1,  8, 0,  0, 0, 0);
    tbl[13] = mk(1, 0, 0,  8, 0,  0, 1, 0);  // ena low: held only
    tbl[14] = mk(1, 0, 1, 16, 0,  0, 1, 0);  // ena raised mid-hold
    tbl[15] = mk(0, 0, 1,  8, 0,  0, 0, 0);

    // Reset held with buttons toggling: everything stays 0.
    rst_n = 1'b0; ena = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      btn_up   = i[0];
      btn_down = ~i[0];
      @(posedge clk);
      #1;
      check("reset up_held", up_held, 0);
      check("reset down_held", down_held, 0);
      check("reset up_pulse", up_pulse, 0);
      check("reset down_pulse", down_pulse, 0);
    end

    // Release reset and press up before edge 0: held and pulse after edge 5.
    rst_n = 1'b1; btn_up = 1'b1; btn_down = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("latency up_held", up_held, (i >= 5) ? 1 : 0);
      check("latency up_pulse", up_pulse, (i == 5) ? 1 : 0);
    end
    btn_up = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    for (int p = 0; p < 16; p++) begin
      btn_up = tbl[p].up; btn_down = tbl[p].dn; ena = tbl[p].en;
      cnt_up = 0; cnt_dn = 0;
      for (int i = 0; i < tbl[p].cycles; i++) tick();
      check($sformatf("phase%0d up pulses", p), cnt_up, tbl[p].exp_up);
      check($sformatf("phase%0d down pulses", p), cnt_dn, tbl[p].exp_dn);
      check($sformatf("phase%0d up_held", p), up_held, tbl[p].exp_uh);
      check($sformatf("phase%0d down_held", p), down_held, tbl[p].exp_dh);
    end

    // REPEAT_DELAY=0 build: a 50-cycle hold gives exactly one pulse.
    btn_up = 1'b1; btn_down = 1'b0; ena = 1'b1;
    cnt_up0 = 0;
    for (int i = 0; i < 50; i++) tick();
    check("norep single pulse", cnt_up0, 1);
    btn_up = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Randomised holds and glitches against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(11) == 0) btn_up = ~btn_up;
      if ($urandom_range(11) == 0) btn_down = ~btn_down;
      if (ena && $urandom_range(39) == 0) ena = 1'b0;
      else if (!ena && $urandom_range(7) == 0) ena = 1'b1;
      tick();
      check("random pulse exclusive", up_pulse & down_pulse, 0);
    end

    // Reset mid-hold: immediate clear, then a fresh press pulse.
    btn_up = 1'b0; btn_down = 1'b0; ena = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_up = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async reset up_held", up_held, 0);
    check("async reset up_pulse", up_pulse, 0);
    check("async reset down_held", down_held, 0);
    check("async reset down_pulse", down_pulse, 0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("re-press up_held", up_held, (i >= 5) ? 1 : 0);
      check("re-press up_pulse", up_pulse, (i == 5) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
